sram22_param_sram_model: RTL
============================

// Module: sram22_param_sram_model
// PURPOSE
//  Parametrised behavioural model of an SRAM22 macro for simulation of the BIST and host paths.
//  Adds four things over a fixed-size single-mask model:
//   - configurable width, depth and write-lane count;
//   - self-clearing after reset;
//   - a pipelined read with a sense-amp enable stage;
//   - explicit read-miss reporting when the selected sense-amp enable is absent.
//  Sits under the BIST wrapper; the BIST engine selects between internal and externally muxed SAE timing.
// PARAMETERS
//  DATA_WIDTH     32  word width in bits; must be divisible by WMASK_WIDTH
//  ADDR_WIDTH     10  address bits; RAM_DEPTH = 1<<ADDR_WIDTH (derived, not overridable)
//  WMASK_WIDTH     4  write lanes; lane k = din[k*LW +: LW], where LW = DATA_WIDTH/WMASK_WIDTH
//  READ_LATENCY    2  2 = accept edge to dout edge; 3 adds one output register; other values are an elaboration error
//  INIT_ON_RESET   1  1 = zero the array after reset; 0 = array retains contents, ready immediately
// PORTS
//  clk        in   1            clock
//  rst_n      in   1            asynchronous active-low reset
//  en         in   1            chip enable; request valid when en=1 and busy=0
//  we         in   1            1 = write, 0 = read
//  wmask      in   WMASK_WIDTH  per-lane write enable
//  addr       in   ADDR_WIDTH   word address
//  din        in   DATA_WIDTH   write data
//  sae_sel    in   1            0 = use sae_int, 1 = use sae_muxed
//  sae_muxed  in   1            externally muxed sense-amp enable
//  sae_int    out  1            internal sense-amp enable, one-cycle pulse
//  dout       out  DATA_WIDTH   read data; held between reads
//  dout_valid out  1            one-cycle pulse when dout is updated
//  rd_miss    out  1            one-cycle pulse when a read sensed with selected SAE = 0
//  busy       out  1            array clear in progress; all requests ignored
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - dout=0, dout_valid=0, rd_miss=0, sae_int=0, all pipeline valids=0, clear pointer=0.
//   - busy=INIT_ON_RESET. The array is not touched asynchronously.
//  FSM, states CLEAR and READY:
//   - Reset enters CLEAR if INIT_ON_RESET=1, else READY.
//   - CLEAR writes zeros to mem[ptr] and increments ptr, one word per cycle.
//   - After writing ptr=RAM_DEPTH-1, go to READY at the next edge (busy=1 for exactly RAM_DEPTH cycles after reset release).
//   - Reset asserted mid-clear restarts the clear from 0.
//  Write, accepted at edge T:
//   - mem[addr] lane k <= din lane k for each wmask[k]=1; wmask=0 is a no-op.
//   - dout and dout_valid are unaffected; a read already in flight completes normally.
//  Read, accepted at edge T:
//   - The array word is snapshotted into the sense register at T.
//   - sae_int=1 during cycle T..T+1 only.
//   - At edge T+1, if the selected SAE (sae_sel ? sae_muxed : sae_int) is 1: dout <= snapshot, dout_valid=1.
//     If it is 0: dout holds its value and rd_miss=1.
//   - READ_LATENCY=3 delays dout, dout_valid and rd_miss by one extra register.
//  Pipelining and ordering:
//   - Back-to-back reads are fully pipelined, one per cycle.
//   - A write at T+1 to the address read at T does not affect that read (old data returned).
//   - A read accepted at T+1 after a write at T returns the new data.
//  Requests with en=1 while busy=1 are dropped silently (no sae_int, no write).
//  sae_muxed is sampled only at the sense edge; it is ignored at all other times.
//  No X is ever driven on dout.
// STRUCTURE
//  sram22_pkg:
//   - state enum {CLEAR, READY};
//   - function lane_width(DATA_WIDTH, WMASK_WIDTH);
//   - localparam checks for divisibility and READ_LATENCY range.
//  Sub-module sram22_sense_stage: snapshot register, SAE select, miss detect and optional output register.
//  Top level holds the array, the write-lane logic and the clear FSM.
// TESTING
//  1. Reset with INIT_ON_RESET=1 -> busy high exactly 1024 cycles; then read 0x000 and 0x3FF -> dout=0, dout_valid pulses.
//  2. Write 0xA5A5A5A5 @0x010 wmask=4'b1111, then write 0x11223344 @0x010 wmask=4'b0101, read 0x010
//     -> dout=0xA522A544 at T+1 (LAT=2) or T+2 (LAT=3).
//  3. Reads at 0x001, 0x002, 0x003 on consecutive cycles, sae_sel=0 -> three consecutive dout_valid pulses, data in order.
//  4. sae_sel=1 with sae_muxed=0 during a read of 0x005 -> rd_miss=1, dout unchanged, dout_valid=0.
//     Repeat with sae_muxed=1 -> data returned.
//  5. Read 0x020 at T, write 0xDEADBEEF @0x020 at T+1 -> dout=old value.
//     Read 0x020 at T+2 -> 0xDEADBEEF.
//  6. Assert rst_n=0 at clear pointer 500 -> outputs zero asynchronously; clear restarts from 0.
//     Request issued while busy=1 -> no sae_int, array unchanged.

Source files
------------

// File: rtl/sram22_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : sram22_pkg                                                     |
// | Purpose  : Shared types, limits and helpers for the SRAM22 macro model.  |
// |            state_t        - array clear FSM states                        |
// |            lane_width()   - bits per write lane                           |
// |            READ_LATENCY_* - legal read latency range                      |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package sram22_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int READ_LATENCY_MIN = 2;
  localparam int READ_LATENCY_MAX = 3;

  function automatic int lane_width(input int data_width, input int wmask_width);
    return data_width / wmask_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram22_param_sram_model_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface: sram22_param_sram_model_if                                     |
// | Purpose  : Request/response bundle between a host (or BIST engine) and   |
// |            the SRAM22 model.                                              |
// |            master: drives en, we, wmask, addr, din, sae_sel, sae_muxed    |
// |            slave : drives sae_int, dout, dout_valid, rd_miss, busy        |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface sram22_param_sram_model_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int WMASK_WIDTH = 4
);
  logic                   en;
  logic                   we;
  logic [WMASK_WIDTH-1:0] wmask;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]  din;
  logic                   sae_sel;
  logic                   sae_muxed;
  logic                   sae_int;
  logic [DATA_WIDTH-1:0]  dout;
  logic                   dout_valid;
  logic                   rd_miss;
  logic                   busy;

  modport master (
    output en, we, wmask, addr, din, sae_sel, sae_muxed,
    input  sae_int, dout, dout_valid, rd_miss, busy
  );

  modport slave (
    input  en, we, wmask, addr, din, sae_sel, sae_muxed,
    output sae_int, dout, dout_valid, rd_miss, busy
  );
endinterface
`default_nettype wire

// File: rtl/sram22_sense_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sram22_sense_stage                                             |
// | Purpose  : Read path of the SRAM22 model: word snapshot, sense-amp enable |
// |            select, miss detection and optional extra output register.     |
// | Ports    : clk, rst_n      - clock, async active-low reset                 |
// |            rd_accept       - read accepted at this edge                   |
// |            rd_word         - array word at the read address               |
// |            sae_sel         - 0 = internal SAE, 1 = sae_muxed              |
// |            sae_muxed       - external SAE, sampled at the sense edge      |
// |            sae_int         - internal SAE pulse                           |
// |            dout/dout_valid - read data and update pulse                   |
// |            rd_miss         - read sensed with selected SAE low            |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sram22_sense_stage #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  rd_accept,
  input  wire logic [DATA_WIDTH-1:0] rd_word,
  input  wire logic                  sae_sel,
  input  wire logic                  sae_muxed,
  output logic                       sae_int,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       dout_valid,
  output logic                       rd_miss
);

  logic [DATA_WIDTH-1:0] snap_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  sense_q;
  logic                  valid_q;
  logic                  miss_q;
  logic                  sae_active;

  // sense_q marks the cycle between accept and sense edge; it doubles as the
  // internal SAE so sae_int needs no separate register.
  assign sae_active = sae_sel ? sae_muxed : sense_q;
  assign sae_int    = sense_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q  <= '0;
      dout_q  <= '0;
      sense_q <= 1'b0;
      valid_q <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      sense_q <= rd_accept;
      if (rd_accept) begin
        snap_q <= rd_word;
      end
      valid_q <= sense_q & sae_active;
      miss_q  <= sense_q & ~sae_active;
      // On a miss dout keeps the previous read's data.
      if (sense_q && sae_active) begin
        dout_q <= snap_q;
      end
    end
  end

  generate
    if (READ_LATENCY == 3) begin : g_out_reg
      logic [DATA_WIDTH-1:0] dout_r;
      logic                  valid_r;
      logic                  miss_r;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_r  <= '0;
          valid_r <= 1'b0;
          miss_r  <= 1'b0;
        end else begin
          dout_r  <= dout_q;
          valid_r <= valid_q;
          miss_r  <= miss_q;
        end
      end

      assign dout       = dout_r;
      assign dout_valid = valid_r;
      assign rd_miss    = miss_r;
    end else begin : g_no_out_reg
      assign dout       = dout_q;
      assign dout_valid = valid_q;
      assign rd_miss    = miss_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/sram22_param_sram_model.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sram22_param_sram_model                                        |
// | Purpose  : Parametrised behavioural SRAM22 macro: lane-masked writes,     |
// |            self-clear after reset, pipelined read with SAE stage and      |
// |            read-miss reporting.                                           |
// | Ports    : clk   - clock                                                  |
// |            rst_n - asynchronous active-low reset                          |
// |            bus   - sram22_param_sram_model_if.slave (request/response)    |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sram22_param_sram_model
  import sram22_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 10,
  parameter int WMASK_WIDTH   = 4,
  parameter int READ_LATENCY  = 2,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  sram22_param_sram_model_if.slave bus
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int LW        = lane_width(DATA_WIDTH, WMASK_WIDTH);

  generate
    if ((DATA_WIDTH % WMASK_WIDTH) != 0) begin : g_bad_lanes
      $error("sram22_param_sram_model: DATA_WIDTH must be divisible by WMASK_WIDTH");
    end
    if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
      $error("sram22_param_sram_model: READ_LATENCY must be 2 or 3");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic                  req_ok;
  logic                  wr_accept;
  logic                  rd_accept;

  assign bus.busy  = (state == CLEAR);
  assign req_ok    = bus.en & ~bus.busy;
  assign wr_accept = req_ok & bus.we;
  assign rd_accept = req_ok & ~bus.we;

  // Clear FSM: one word per cycle, READY after the last address is zeroed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT_ON_RESET ? CLEAR : READY;
      clr_ptr <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
            state <= READY;
          end
        end
        READY:   state <= READY;
        default: state <= READY;
      endcase
    end
  end

  // The array has no reset; it is only ever changed on a clock edge.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (wr_accept) begin
      for (int k = 0; k < WMASK_WIDTH; k++) begin
        if (bus.wmask[k]) begin
          mem[bus.addr][k*LW +: LW] <= bus.din[k*LW +: LW];
        end
      end
    end
  end

  sram22_sense_stage #(
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_sense (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_accept  (rd_accept),
    .rd_word    (mem[bus.addr]),
    .sae_sel    (bus.sae_sel),
    .sae_muxed  (bus.sae_muxed),
    .sae_int    (bus.sae_int),
    .dout       (bus.dout),
    .dout_valid (bus.dout_valid),
    .rd_miss    (bus.rd_miss)
  );

endmodule
`default_nettype wire
